uc_multiciclo: RTL
==================

UC_MULTICICLO -- requirements
Module: uc_multiciclo

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 op  in  7  opcode field of the instruction register.
REQ-005 f3  in  3  funct3 field.
REQ-006 f7  in  7  funct7 field; only bit 5 is used.
REQ-007 zero  in  1  ALU zero flag.
REQ-008 memReady  in  1  unified memory access complete this cycle.
REQ-009 pcWrite  out  1  PC register write enable.
REQ-010 adrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
REQ-011 memWrite  out  1  memory write strobe.
REQ-012 irWrite  out  1  instruction register write enable.
REQ-013 resultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult.
REQ-014 aluSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1 data.
REQ-015 aluSrcB  out  2  ALU B select: 00=rs2 data, 01=ImmExt, 10=constant 4.
REQ-016 immSrc  out  2  immediate format: 00=I, 01=S, 10=B, 11=J.
REQ-017 regWrite  out  1  register file write enable.
REQ-018 aluControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-019 state  out  4  current FSM state; debug/verification only.

Function
REQ-020 The FSM SHALL use these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10.
REQ-021 Supported opcodes SHALL be lw=0000011, sw=0100011, R=0110011, I=0010011, beq=1100011, jal=1101111.
REQ-022 Transitions:
- FETCH goes to DECODE only when memReady=1; otherwise it stays in FETCH.
- DECODE goes to MEMADR for lw or sw, EXECUTER for R, EXECUTEI for I, JAL for jal, BEQ for beq, and FETCH for any other opcode.
REQ-023 Further transitions:
- MEMADR goes to MEMREAD for lw and MEMWRITE for sw.
- MEMREAD goes to MEMWB when memReady=1; otherwise it stays.
- MEMWRITE goes to FETCH when memReady=1; otherwise it stays.
- EXECUTER, EXECUTEI and JAL go to ALUWB.
- MEMWB, ALUWB and BEQ go to FETCH.
- Unused encodings 11..15 go to FETCH.
REQ-024 Per-state outputs; every signal not listed SHALL be 0:
- FETCH: aluSrcB=10, resultSrc=10, irWrite=memReady, pcWrite=memReady.
- DECODE: aluSrcA=01, aluSrcB=01.
- MEMADR and EXECUTEI: aluSrcA=10, aluSrcB=01.
- MEMREAD: adrSrc=1.
- MEMWRITE: adrSrc=1, memWrite=1, held for every cycle spent in MEMWRITE.
- MEMWB: resultSrc=01, regWrite=1.
- EXECUTER: aluSrcA=10.
- ALUWB: regWrite=1.
- JAL: aluSrcA=01, aluSrcB=10, pcWrite=1.
- BEQ: aluSrcA=10, pcWrite=zero.
REQ-025 Internal aluOp SHALL be 01 in BEQ, 10 in EXECUTER and EXECUTEI, and 00 in all other states.
REQ-026 aluControl decoding:
- aluOp=00 gives 000; aluOp=01 gives 001.
- aluOp=10 decodes by f3: 000 gives 001 if op[5]&f7[5], else 000; 010 gives 101; 110 gives 011; 111 gives 010; all other f3 give 000.
REQ-027 immSrc SHALL decode combinationally from op in every state: sw gives 01, beq gives 10, jal gives 11, all others give 00.
REQ-028 memReady SHALL be ignored in states other than FETCH, MEMREAD and MEMWRITE.
REQ-029 Instruction latencies in cycles, with memReady=1 throughout:
- lw: 5; sw: 4; R and I: 4; jal: 4; beq: 3.
- Illegal opcode: 2 cycles, with no register or memory write.

Reset
REQ-030 When reset=0, state SHALL become FETCH immediately, without waiting for a clock edge.
REQ-031 While reset=0, pcWrite, irWrite, memWrite and regWrite SHALL be forced to 0, overriding REQ-024.
REQ-032 Reset asserted in any state, including mid-MEMWRITE, SHALL abort the instruction; no strobe may be asserted after reset goes low.
REQ-033 After reset deasserts, the first rising edge SHALL evaluate the FETCH transition rule.

Verification
REQ-034 lw (op=0000011), memReady=1 -> state sequence 0,1,2,3,4,0; regWrite=1 only in state 4, with resultSrc=01.
REQ-035 sw, with memReady=0 for 3 cycles in MEMWRITE -> memWrite=1 for exactly 4 cycles, then return to FETCH.
REQ-036 beq with zero=1, then beq with zero=0 -> pcWrite=1 in BEQ for the first and 0 for the second; aluControl=001 in both.
REQ-037 R-type sub (f3=000, f7=0100000), then I-type addi with f7[5]=1 -> aluControl=001 for sub and 000 for addi in the execute state.
REQ-038 Reset pulsed low mid-EXECUTER -> state=0 immediately and all strobes 0 while low; illegal opcode 1111111 -> 1,0 sequence with no writes.

Source files
------------

// File: rtl/uc_multiciclo.sv
// Multicycle RISC-V control unit (lw, sw, R-type, I-type ALU, beq, jal).
//
// Ports:
//   clk        - single clock, rising-edge state updates
//   reset      - asynchronous active-low reset (0 = reset asserted)
//   op/f3/f7   - opcode, funct3 and funct7 fields of the instruction register
//   zero       - ALU zero flag, drives the beq PC update
//   memReady   - unified memory access complete this cycle
//   pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
//   immSrc, regWrite, aluControl - datapath controls
//   state      - current FSM state, for debug/verification only
module uc_multiciclo (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] immSrc,
  output logic       regWrite,
  output logic [2:0] aluControl,
  output logic [3:0] state
);

  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpSw   = 7'b0100011;
  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpBeq  = 7'b1100011;
  localparam logic [6:0] OpJal  = 7'b1101111;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StAluWb    = 4'd7,
    StExecuteI = 4'd8,
    StJal      = 4'd9,
    StBeq      = 4'd10
  } state_t;

  state_t     stateQ, stateD;
  logic [1:0] aluOp;
  logic       pcWr, memWr, irWr, regWr;

  // Only f7[5] distinguishes sub from add.
  logic unusedF7;
  assign unusedF7 = ^{f7[6], f7[4:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= StFetch;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = StFetch;
    case (stateQ)
      StFetch:    stateD = memReady ? StDecode : StFetch;
      StDecode: begin
        case (op)
          OpLw, OpSw: stateD = StMemAdr;
          OpR:        stateD = StExecuteR;
          OpI:        stateD = StExecuteI;
          OpJal:      stateD = StJal;
          OpBeq:      stateD = StBeq;
          default:    stateD = StFetch;
        endcase
      end
      StMemAdr: begin
        if (op == OpLw) begin
          stateD = StMemRead;
        end else if (op == OpSw) begin
          stateD = StMemWrite;
        end else begin
          stateD = StFetch;
        end
      end
      StMemRead:  stateD = memReady ? StMemWb : StMemRead;
      StMemWrite: stateD = memReady ? StFetch : StMemWrite;
      StExecuteR, StExecuteI, StJal: stateD = StAluWb;
      default:    stateD = StFetch;
    endcase
  end

  always_comb begin
    pcWr      = 1'b0;
    adrSrc    = 1'b0;
    memWr     = 1'b0;
    irWr      = 1'b0;
    resultSrc = 2'b00;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    regWr     = 1'b0;
    aluOp     = 2'b00;
    case (stateQ)
      StFetch: begin
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
        irWr      = memReady;
        pcWr      = memReady;
      end
      StDecode: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
      end
      StMemAdr: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
      end
      StMemRead:  adrSrc = 1'b1;
      StMemWrite: begin
        adrSrc = 1'b1;
        memWr  = 1'b1;
      end
      StMemWb: begin
        resultSrc = 2'b01;
        regWr     = 1'b1;
      end
      StExecuteR: begin
        aluSrcA = 2'b10;
        aluOp   = 2'b10;
      end
      StExecuteI: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        aluOp   = 2'b10;
      end
      StAluWb:    regWr = 1'b1;
      StJal: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b10;
        pcWr    = 1'b1;
      end
      StBeq: begin
        aluSrcA = 2'b10;
        pcWr    = zero;
        aluOp   = 2'b01;
      end
      default: ;
    endcase
  end

  always_comb begin
    aluControl = 3'b000;
    case (aluOp)
      2'b01: aluControl = 3'b001;
      2'b10: begin
        case (f3)
          3'b000:  aluControl = (op[5] & f7[5]) ? 3'b001 : 3'b000;
          3'b010:  aluControl = 3'b101;
          3'b110:  aluControl = 3'b011;
          3'b111:  aluControl = 3'b010;
          default: aluControl = 3'b000;
        endcase
      end
      default: aluControl = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OpSw:    immSrc = 2'b01;
      OpBeq:   immSrc = 2'b10;
      OpJal:   immSrc = 2'b11;
      default: immSrc = 2'b00;
    endcase
  end

  // Strobes are gated by the raw reset so they drop in the same instant reset falls.
  assign pcWrite  = pcWr & reset;
  assign irWrite  = irWr & reset;
  assign memWrite = memWr & reset;
  assign regWrite = regWr & reset;
  assign state    = stateQ;

endmodule
